// File: rtl/qe_edge.sv
// qe_edge: quadrature input conditioning - synchroniser, glitch filter, edge strobes, direction and error.
// Define QE_FILTER_EN to enable the FILT_LEN-cycle glitch filter; without it the filtered level follows the synchroniser.
module qe_edge #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic q_raw,
  input  logic clr,
  output logic i,
  output logic i_r,
  output logic i_f,
  output logic q,
  output logic q_r,
  output logic q_f,
  output logic step,
  output logic dir,
  output logic err,
  output logic err_flag,
  output logic ready
);

`ifdef QE_FILTER_EN
  localparam int ARM_LEN = FILT_LEN + 2;
  localparam int CNT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
`else
  // FILT_LEN has no effect without the filter; the arm period equals the FILT_LEN = 1 case.
  localparam int ARM_LEN = (FILT_LEN > 0) ? 3 : 3;
`endif
  localparam int ARM_W = $clog2(ARM_LEN + 1);

  logic [1:0]       w_raw;
  logic [1:0]       w_f;
  logic [1:0]       w_chg;
  logic [1:0]       r_fd;
  logic [ARM_W-1:0] r_arm;
  logic             r_live;
  logic             r_dir;
  logic             r_err_flag;
  logic             w_ready;
  logic             w_illegal;
  logic             w_gate;
  logic             w_err;
  logic             w_step;
  logic             w_up;
  logic             w_ir;
  logic             w_if;
  logic             w_qr;
  logic             w_qf;

  assign w_raw = {q_raw, i_raw};

  // Bit 0 carries channel I, bit 1 carries channel Q.
  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic r_s1;
    logic r_s2;
    logic r_f;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_raw[ch];
        r_s2 <= r_s1;
      end
    end

`ifdef QE_FILTER_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_f   <= 1'b0;
        r_cnt <= '0;
      end else if (r_s2 == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
        r_f   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_f <= 1'b0;
      end else begin
        r_f <= r_s2;
      end
    end
`endif

    assign w_f[ch] = r_f;
  end

  // A level held through reset reaches f on the very edge the arm counter completes,
  // so strobes open one cycle after ready to keep that first settle from looking like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fd   <= 2'b00;
      r_arm  <= '0;
      r_live <= 1'b0;
    end else begin
      r_fd   <= w_f;
      r_live <= w_ready;
      if (!w_ready) begin
        r_arm <= r_arm + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir      <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      if (w_step) begin
        r_dir <= w_up;
      end
      if (w_err) begin
        r_err_flag <= 1'b1;
      end else if (clr) begin
        r_err_flag <= 1'b0;
      end
    end
  end

  assign w_ready   = (r_arm == ARM_W'(ARM_LEN));
  assign w_chg     = w_f ^ r_fd;
  assign w_illegal = &w_chg;
  assign w_gate    = r_live & ~w_illegal;
  assign w_err     = r_live & w_illegal;

  assign w_ir   = w_gate &  w_f[0] & ~r_fd[0];
  assign w_if   = w_gate & ~w_f[0] &  r_fd[0];
  assign w_qr   = w_gate &  w_f[1] & ~r_fd[1];
  assign w_qf   = w_gate & ~w_f[1] &  r_fd[1];
  assign w_step = w_ir | w_if | w_qr | w_qf;
  assign w_up   = (w_ir & ~w_f[1]) | (w_if & w_f[1]) | (w_qr & w_f[0]) | (w_qf & ~w_f[0]);

  assign i        = w_f[0];
  assign q        = w_f[1];
  assign i_r      = w_ir;
  assign i_f      = w_if;
  assign q_r      = w_qr;
  assign q_f      = w_qf;
  assign step     = w_step;
  assign dir      = r_dir;
  assign err      = w_err;
  assign err_flag = r_err_flag;
  assign ready    = w_ready;

endmodule

// File: tb/tb_qe_edge.sv
// tb_qe_edge: directed bench for qe_edge with a run-length reference model and per-cycle output comparison.
module tb_qe_edge;

  localparam int FILT = 4;
`ifdef QE_FILTER_EN
  localparam int FLE = FILT;
`else
  localparam int FLE = 1;
`endif
  localparam int ARM         = FLE + 2;
  localparam int SHORT_STEPS = (3 < FLE) ? 0 : 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_raw = 1'b0;
  logic q_raw = 1'b0;
  logic clr = 1'b0;
  logic i, i_r, i_f, q, q_r, q_f, step, dir, err, err_flag, ready;
  logic [10:0] actV;

  int checks = 0;
  int errors = 0;
  int stepCount = 0;
  int errCount = 0;

  qe_edge #(.FILT_LEN(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .i_raw(i_raw), .q_raw(q_raw), .clr(clr),
    .i(i), .i_r(i_r), .i_f(i_f), .q(q), .q_r(q_r), .q_f(q_f),
    .step(step), .dir(dir), .err(err), .err_flag(err_flag), .ready(ready)
  );

  always #5 clk = ~clk;

  assign actV = {i, i_r, i_f, q, q_r, q_f, step, dir, err, err_flag, ready};

  // Reference model: a filtered level adopts the synchronised value once that value
  // has been seen, unchanged and different from the level, on FLE consecutive edges.
  int          e = 0;
  bit [1:0]    p1, p2, s2pre, lastS2, fM, fdM, chg;
  int          runLen[2];
  bit          dirM, flagM, prevStep, prevUp, prevErr;
  bit          live, rdy, errNow, ir, ifl, qr, qfl, stepNow, upNow;
  logic [10:0] expV = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; p1 = 0; p2 = 0; lastS2 = 0; fM = 0; fdM = 0;
      runLen[0] = 0; runLen[1] = 0;
      dirM = 0; flagM = 0; prevStep = 0; prevUp = 0; prevErr = 0;
      expV = '0;
    end else begin
      e++;
      if (prevStep) dirM = prevUp;
      if (prevErr) flagM = 1'b1;
      else if (clr) flagM = 1'b0;
      s2pre = p2;
      p2 = p1;
      p1 = {q_raw, i_raw};
      for (int c = 0; c < 2; c++) begin
        if (s2pre[c] == lastS2[c]) runLen[c]++;
        else runLen[c] = 1;
        lastS2[c] = s2pre[c];
        fdM[c] = fM[c];
        if (s2pre[c] != fM[c] && runLen[c] >= FLE) fM[c] = s2pre[c];
      end
      chg     = fM ^ fdM;
      rdy     = (e >= ARM);
      live    = (e >= ARM + 1);
      errNow  = live && (chg == 2'b11);
      ir      = live && !errNow &&  fM[0] && !fdM[0];
      ifl     = live && !errNow && !fM[0] &&  fdM[0];
      qr      = live && !errNow &&  fM[1] && !fdM[1];
      qfl     = live && !errNow && !fM[1] &&  fdM[1];
      stepNow = ir || ifl || qr || qfl;
      upNow   = (ir && !fM[1]) || (ifl && fM[1]) || (qr && fM[0]) || (qfl && !fM[0]);
      expV    = {fM[0], ir, ifl, fM[1], qr, qfl, stepNow, dirM, errNow, flagM, rdy};
      prevStep = stepNow;
      prevUp   = upNow;
      prevErr  = errNow;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (actV !== expV) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t {i,i_r,i_f,q,q_r,q_f,step,dir,err,err_flag,ready} got %b expected %b",
               $time, actV, expV);
    end
    if (step === 1'b1) stepCount++;
    if (err === 1'b1) errCount++;
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit [1:0] iq, input int hold);
    i_raw = iq[1];
    q_raw = iq[0];
    waitEdges(hold);
  endtask

  task automatic checkOutput(input string name, input int act, input int expd);
    checks++;
    if (act != expd) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, expd);
    end
  endtask

  typedef struct { bit [1:0] iq; int hold; bit c; } vec_t;
  vec_t table_v[$];
  int baseSteps, baseErrs;

  initial begin
    rst_n = 1'b0;
    i_raw = 1'b1;
    q_raw = 1'b1;
    waitEdges(3);
    checkOutput("resetOutputs", int'(actV), 0);
    baseSteps = stepCount;
    rst_n = 1'b1;
    waitEdges(ARM - 1);
    checkOutput("readyBeforeArm", int'(ready), 0);
    waitEdges(1);
    checkOutput("readyAfterArm", int'(ready), 1);
    waitEdges(6);
    checkOutput("startupLevelI", int'(i), 1);
    checkOutput("startupLevelQ", int'(q), 1);
    checkOutput("startupNoStep", stepCount - baseSteps, 0);

    applyStimulus(2'b10, 10);
    applyStimulus(2'b00, 10);

    // Forward 00->10->11->01->00; the first change pins the strobe latency.
    baseSteps = stepCount;
    i_raw = 1'b1;
    waitEdges(1 + FLE);
    checkOutput("latencyIrEarly", int'(i_r), 0);
    waitEdges(1);
    checkOutput("latencyIrHigh", int'(i_r), 1);
    checkOutput("latencyStep", int'(step), 1);
    waitEdges(1);
    checkOutput("latencyIrLow", int'(i_r), 0);
    waitEdges(10 - (3 + FLE));
    applyStimulus(2'b11, 10);
    applyStimulus(2'b01, 10);
    applyStimulus(2'b00, 10);
    checkOutput("forwardSteps", stepCount - baseSteps, 4);
    checkOutput("forwardDir", int'(dir), 1);
    checkOutput("forwardNoErr", int'(err_flag), 0);

    baseSteps = stepCount;
    applyStimulus(2'b01, 10);
    checkOutput("reverseFirstDir", int'(dir), 0);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b00, 10);
    checkOutput("reverseSteps", stepCount - baseSteps, 4);
    checkOutput("reverseDir", int'(dir), 0);

    baseSteps = stepCount;
    applyStimulus(2'b10, 3);
    applyStimulus(2'b00, 12);
    checkOutput("shortPulseSteps", stepCount - baseSteps, SHORT_STEPS);
    checkOutput("shortPulseLevel", int'(i), 0);
    baseSteps = stepCount;
    applyStimulus(2'b10, 4);
    applyStimulus(2'b00, 12);
    checkOutput("longPulseSteps", stepCount - baseSteps, 2);

    baseSteps = stepCount;
    baseErrs = errCount;
    applyStimulus(2'b11, 12);
    checkOutput("illegalErrPulses", errCount - baseErrs, 1);
    checkOutput("illegalNoStep", stepCount - baseSteps, 0);
    checkOutput("illegalFlag", int'(err_flag), 1);
    checkOutput("illegalDirHeld", int'(dir), 0);
    checkOutput("illegalLevels", int'({i, q}), 3);
    clr = 1'b1;
    waitEdges(1);
    clr = 1'b0;
    checkOutput("clrFlag", int'(err_flag), 0);

    // Clear held across a second illegal change: set wins for one edge, then clears.
    clr = 1'b1;
    applyStimulus(2'b00, 12);
    clr = 1'b0;
    checkOutput("setBeatsClrThenClear", int'(err_flag), 0);

    applyStimulus(2'b10, FLE + 2);
    checkOutput("preResetStrobe", int'(i_r), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetOutputs", int'(actV), 0);
    baseSteps = stepCount;
    waitEdges(2);
    rst_n = 1'b1;
    waitEdges(ARM + 6);
    checkOutput("postResetNoStep", stepCount - baseSteps, 0);
    checkOutput("postResetLevelI", int'(i), 1);

    table_v = '{
      '{2'b11, 3, 1'b0}, '{2'b01, 8, 1'b0}, '{2'b00, 2, 1'b1}, '{2'b01, 1, 1'b0},
      '{2'b00, 9, 1'b0}, '{2'b10, 5, 1'b0}, '{2'b11, 4, 1'b0}, '{2'b10, 2, 1'b0},
      '{2'b00, 12, 1'b0}, '{2'b11, 6, 1'b0}, '{2'b01, 6, 1'b1}, '{2'b00, 10, 1'b0}
    };
    foreach (table_v[n]) begin
      clr = table_v[n].c;
      applyStimulus(table_v[n].iq, table_v[n].hold);
    end
    clr = 1'b0;
    waitEdges(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
